// File: rtl/prince_inv_slayer_seq.sv
// prince_inv_slayer_seq
//   Sequential PRINCE inverse S-layer. A 64-bit state word is captured into a
//   working register. NPAR nibbles per cycle are then substituted in place,
//   starting from nibble 0, until all 16 have passed through the inverse
//   S-box. The result is held behind a valid/ready handshake.
//
// Parameters
//   NPAR      nibbles substituted per cycle (1, 2, 4, 8 or 16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream offers in_data
//   in_ready   block can accept a word (IDLE, or DONE with out_ready)
//   in_data    state word, nibble k = bits [4k:4k+3], nibble 0 first
//   out_valid  out_data holds a completed result
//   out_ready  downstream takes the result
//   out_data   working register, including partial values while busy
module prince_inv_slayer_seq #(
  parameter int NPAR = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_data
);

  localparam int NGRP = 16 / NPAR;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (NPAR != 1 && NPAR != 2 && NPAR != 4 && NPAR != 8 && NPAR != 16) begin : g_bad_npar
    $error("prince_inv_slayer_seq: NPAR must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [0:63]   data_q;
  logic [0:63]   sub_data;
  logic          accept;
  logic          last_grp;

  function automatic logic [3:0] inv_sbox(input logic [3:0] v);
    inv_sbox = 4'h0;
    unique case (v)
      4'h0: inv_sbox = 4'hB;
      4'h1: inv_sbox = 4'h7;
      4'h2: inv_sbox = 4'h3;
      4'h3: inv_sbox = 4'h2;
      4'h4: inv_sbox = 4'hF;
      4'h5: inv_sbox = 4'hD;
      4'h6: inv_sbox = 4'h8;
      4'h7: inv_sbox = 4'h9;
      4'h8: inv_sbox = 4'hA;
      4'h9: inv_sbox = 4'h6;
      4'hA: inv_sbox = 4'h4;
      4'hB: inv_sbox = 4'h0;
      4'hC: inv_sbox = 4'h5;
      4'hD: inv_sbox = 4'hE;
      4'hE: inv_sbox = 4'hC;
      4'hF: inv_sbox = 4'h1;
    endcase
  endfunction

  // Only the nibbles belonging to the current group are replaced. The group
  // test uses constants per k, so it reduces to a small decode of cnt_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sub_data = data_q;
    for (int k = 0; k < 16; k++) begin
      if ((k / NPAR) == int'(cnt_q)) begin
        sub_data[4*k +: 4] = inv_sbox(data_q[4*k +: 4]);
      end
    end
  end

  assign last_grp  = (cnt_q == CW'(NGRP - 1));
  // out_ready reaches in_ready combinationally so a finished word can be
  // handed off and a new one accepted on the same edge.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            data_q  <= in_data;
            cnt_q   <= '0;
            state_q <= BUSY;
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          data_q <= sub_data;
          cnt_q  <= cnt_q + 1'b1;
          if (last_grp) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prince_inv_slayer_seq.sv
// tb_prince_inv_slayer_seq
//   Five instances (NPAR = 1, 2, 4, 8, 16) share all inputs; index 2 is the
//   default NPAR=4 instance that carries the handshake scenarios. Expected
//   results come from a table-driven nibble model of the inverse S-layer.
module tb_prince_inv_slayer_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [0:63] in_data;

  logic        in_ready_a  [5];
  logic        out_valid_a [5];
  logic [0:63] out_data_a  [5];

  int total;
  int bad;

  localparam logic [3:0] INV_TBL [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  for (genvar g = 0; g < 5; g++) begin : g_dut
    prince_inv_slayer_seq #(.NPAR(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready),
      .out_data  (out_data_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word after the first groups*npar nibbles have been inverted.
  function automatic logic [0:63] partial(input logic [0:63] w, input int groups, input int npar);
    logic [0:63] r;
    r = w;
    for (int k = 0; k < 16; k++) begin
      if (k < groups * npar) r[4*k +: 4] = INV_TBL[w[4*k +: 4]];
    end
    return r;
  endfunction

  function automatic logic [0:63] inv_layer(input logic [0:63] w);
    return partial(w, 16, 1);
  endfunction

  task automatic reset_dut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic accept_word(input logic [0:63] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge after the accepting edge; checks partial contents
  // each busy cycle, then the latency and final value of the NPAR=4 instance.
  task automatic wait_result(input logic [0:63] w, input logic [0:63] exp);
    int n;
    n = 0;
    while (!out_valid_a[2] && n < 40) begin
      total++;
      if (out_data_a[2] !== partial(w, n, 4)) begin
        bad++;
        $display("FAIL partial_%0d: got %h want %h", n, out_data_a[2], partial(w, n, 4));
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL latency_npar4: got %0d want 4", n);
    end
    total++;
    if (out_data_a[2] !== exp) begin
      bad++;
      $display("FAIL result_npar4: got %h want %h", out_data_a[2], exp);
    end
  endtask

  task automatic release_result();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0) begin
      bad++;
      $display("FAIL release_idle: got ready=%b valid=%b want ready=1 valid=0",
               in_ready_a[2], out_valid_a[2]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready_a[i] !== 1'b1 || out_valid_a[i] !== 1'b0 || out_data_a[i] !== 64'h0) begin
        bad++;
        $display("FAIL reset_state_%0d: got ready=%b valid=%b data=%h want 1 0 0",
                 i, in_ready_a[i], out_valid_a[i], out_data_a[i]);
      end
    end
  endtask

  // All instances must be idle on entry.
  task automatic test_all_npar(input logic [0:63] w, input logic [0:63] exp);
    int          lat  [5];
    logic [0:63] seen [5];
    for (int i = 0; i < 5; i++) begin
      lat[i]  = -1;
      seen[i] = '0;
    end
    accept_word(w);
    for (int n = 0; n < 18; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (out_valid_a[i] && lat[i] < 0) begin
          lat[i]  = n;
          seen[i] = out_data_a[i];
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (lat[i] !== (16 >> i)) begin
        bad++;
        $display("FAIL latency_npar%0d: got %0d want %0d", 1 << i, lat[i], 16 >> i);
      end
      total++;
      if (seen[i] !== exp) begin
        bad++;
        $display("FAIL result_npar%0d: got %h want %h", 1 << i, seen[i], exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_zero();
    accept_word(64'h0);
    wait_result(64'h0, 64'hBBBB_BBBB_BBBB_BBBB);
    release_result();
  endtask

  task automatic test_forward();
    accept_word(64'hBF32_AC91_6780_E5D4);
    wait_result(64'hBF32_AC91_6780_E5D4, 64'h0123_4567_89AB_CDEF);
    release_result();
  endtask

  task automatic test_random();
    logic [0:63] w;
    int          hold;
    for (int t = 0; t < 6; t++) begin
      w    = {$urandom(), $urandom()};
      hold = $urandom_range(0, 3);
      accept_word(w);
      wait_result(w, inv_layer(w));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        total++;
        if (out_valid_a[2] !== 1'b1 || out_data_a[2] !== inv_layer(w)) begin
          bad++;
          $display("FAIL random_hold: got valid=%b data=%h want 1 %h",
                   out_valid_a[2], out_data_a[2], inv_layer(w));
        end
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [0:63] w;
    w = 64'h1357_9BDF_0246_8ACE;
    accept_word(w);
    wait_result(w, inv_layer(w));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = ~w;
      #1;
      total++;
      if (out_valid_a[2] !== 1'b1 || out_data_a[2] !== inv_layer(w) || in_ready_a[2] !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: got valid=%b ready=%b data=%h want 1 0 %h",
                 c, out_valid_a[2], in_ready_a[2], out_data_a[2], inv_layer(w));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [0:63] a;
    logic [0:63] b;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    accept_word(a);
    wait_result(a, inv_layer(a));
    in_valid  = 1'b1;
    in_data   = b;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready_a[2] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got %b want 1", in_ready_a[2]);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_result(b, inv_layer(b));
    release_result();
  endtask

  task automatic test_reset_busy();
    logic [0:63] w;
    w = 64'hFEDC_BA98_7654_3210;
    accept_word(w);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (out_valid_a[2] !== 1'b0 || out_data_a[2] !== 64'h0 || in_ready_a[2] !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy: got valid=%b ready=%b data=%h want 0 1 0",
               out_valid_a[2], in_ready_a[2], out_data_a[2]);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (out_valid_a[2] !== 1'b0 || out_data_a[2] !== 64'h0) begin
        bad++;
        $display("FAIL reset_busy_quiet_%0d: got valid=%b data=%h want 0 0",
                 c, out_valid_a[2], out_data_a[2]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_dut();
    test_reset();
    test_all_npar(64'h0123_4567_89AB_CDEF, 64'hB732_FD89_A640_5EC1);
    reset_dut();
    begin
      logic [0:63] w;
      w = {$urandom(), $urandom()};
      test_all_npar(w, inv_layer(w));
    end
    reset_dut();
    test_zero();
    test_forward();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prince_inv_slayer_seq.md
PRINCE_INV_SLAYER_SEQ -- requirements
Module: prince_inv_slayer_seq

Interface
REQ-001 SHALL have parameter NPAR, default 4, meaning nibbles substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream has a 64-bit state word.
REQ-005 SHALL have port in_ready  output  1  block can accept a word.
REQ-006 SHALL have port in_data  input  [0:63]  state word; nibble k = bits [4k:4k+3], nibble 0 MSB-first.
REQ-007 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port out_data  output  [0:63]  working register contents, same nibble order as in_data.

Function
REQ-010 SHALL apply the PRINCE inverse S-box to all 16 nibbles (decryption S-layer), mapping 0..F to B,7,3,2,F,D,8,9,A,6,4,0,5,E,C,1.
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE, plus a group counter of width ceil(log2(16/NPAR)), minimum 1 bit.
REQ-012 SHALL drive in_ready = (state==IDLE) OR (state==DONE AND out_ready); the out_ready-to-in_ready path is combinational.
REQ-013 SHALL drive out_valid = (state==DONE), registered.
REQ-014 SHALL accept on any edge where in_valid AND in_ready: load in_data into the working register, clear the counter, enter BUSY.
REQ-015 In BUSY, each edge SHALL substitute nibbles [count*NPAR .. count*NPAR+NPAR-1] in place, leave all other nibbles unchanged, and increment the counter.
REQ-016 On the edge that substitutes the last group (count = 16/NPAR-1), the block SHALL enter DONE.
REQ-017 Latency SHALL be 16/NPAR cycles: out_valid rises exactly 16/NPAR edges after the accepting edge (4 for the default).
REQ-018 In DONE without out_ready, out_data and out_valid SHALL hold indefinitely; in_valid SHALL be ignored.
REQ-019 In DONE with out_ready and no in_valid, the block SHALL return to IDLE on that edge.
REQ-020 In DONE with out_ready and in_valid together, the block SHALL hand off and accept the new word on the same edge and enter BUSY, giving back-to-back throughput of one word per 16/NPAR+1 cycles.
REQ-021 In IDLE and BUSY, out_ready SHALL have no effect; in BUSY, in_valid SHALL be ignored (in_ready=0).
REQ-022 With NPAR=16, BUSY SHALL last exactly one cycle.
REQ-023 out_data SHALL continuously reflect the working register, including partially substituted values during BUSY.

Reset
REQ-024 While rst_n=0 at a rising edge, the next state SHALL be IDLE, the counter 0, the working register 0, and out_valid 0.
REQ-025 After reset, in_ready SHALL be 1 and out_data SHALL be 64'h0.
REQ-026 Reset asserted in BUSY or DONE SHALL discard the word in progress with no out_valid pulse; rst_n has priority over all other inputs.

Verification
REQ-027 The bench SHALL cover: after reset, in_data=64'h0, NPAR=4 -> out_valid 4 cycles after accept, out_data=BBBBBBBBBBBBBBBB.
REQ-028 The bench SHALL cover: in_data=0123456789ABCDEF -> out_data=B732FD89A6405EC1, for each NPAR in {1,2,4,8,16}, with latency 16, 8, 4, 2, 1.
REQ-029 The bench SHALL cover: in_data=BF32AC916780E5D4 (forward S-layer of 0123456789ABCDEF) -> out_data=0123456789ABCDEF.
REQ-030 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_data is stable, and in_ready=0 throughout.
REQ-031 The bench SHALL cover: in_valid and out_ready both 1 in DONE -> handoff and new accept on the same edge, with the next out_valid exactly 4 edges later (NPAR=4).
REQ-032 The bench SHALL cover: rst_n=0 for one cycle on the second BUSY cycle -> IDLE with out_data=0, no out_valid, and in_ready=1 on the next cycle.
